// File: rtl/power_seq_pkg.sv
// power_seq_pkg: shared state encoding, fault codes and register map for the power sequencer
package power_seq_pkg;
   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_RAMP0    = 3'd1,
      ST_SETTLE0  = 3'd2,
      ST_RAMP1    = 3'd3,
      ST_ON       = 3'd4,
      ST_SHUTDOWN = 3'd5,
      ST_FAULT    = 3'd6
   } state_e;
   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_TO_RAMP0 = 3'd1;
   localparam logic [2:0] FC_TO_RAMP1 = 3'd2;
   localparam logic [2:0] FC_LOSS0    = 3'd3;
   localparam logic [2:0] FC_LOSS1    = 3'd4;
   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
   localparam logic [1:0] ADDR_SETTLE  = 2'd3;
   function automatic logic [1:0] rail_ctl(input state_e s);
      return (s == ST_RAMP1 || s == ST_ON) ? 2'b11 :
             (s == ST_RAMP0 || s == ST_SETTLE0 || s == ST_SHUTDOWN) ? 2'b01 : 2'b00;
   endfunction
endpackage

// File: rtl/power_sense_sync.sv
// power_sense_sync: parameterised-width two-flop synchronizer for the power-good inputs
module power_sense_sync #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] meta_q, sync_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end
   assign q_o = sync_q;
endmodule

// File: rtl/power_sequencer.sv
// power_sequencer: Avalon-MM controlled two-rail power sequencer with power-good monitoring and sticky faults
module power_sequencer
   import power_seq_pkg::*;
#(
   parameter int unsigned       SENSE_W     = 6,
   parameter logic [SENSE_W-1:0] RAIL0_MASK = 6'b000111,
   parameter logic [SENSE_W-1:0] RAIL1_MASK = 6'b111000,
   parameter logic [31:0]       TIMEOUT_RST = 32'd5000000,
   parameter logic [31:0]       SETTLE_RST  = 32'd500000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         avs_address,
   input  logic               avs_read,
   input  logic               avs_write,
   input  logic [31:0]        avs_writedata,
   output logic [31:0]        avs_readdata,
   output logic [1:0]         power_control,
   input  logic [SENSE_W-1:0] power_sense,
   output logic               irq
);
   state_e             state_q, state_d;
   logic [2:0]         fault_q, fault_d;
   logic               en_q, en_d, irq_en_q, irq_en_d;
   logic [31:0]        timeout_q, timeout_d, settle_q, settle_d, cnt_q, cnt_d;
   logic [31:0]        rdata_q, rdata_d, status;
   logic [1:0]         ctl_q;
   logic [SENSE_W-1:0] sense_s;
   logic               good0, good1, timeout_hit, settle_done, clear_fault;

   power_sense_sync #(.W(SENSE_W)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (power_sense),
      .q_o   (sense_s)
   );

   // Unmasked bits are forced high, so an empty mask reads as always good.
   assign good0       = &(sense_s | ~RAIL0_MASK);
   assign good1       = &(sense_s | ~RAIL1_MASK);
   assign timeout_hit = (timeout_q != 32'd0) && (cnt_q >= timeout_q);
   assign settle_done = cnt_q >= settle_q;
   assign clear_fault = avs_write && avs_address == ADDR_CTRL && avs_writedata[2];

   always_comb begin
      status = '0;
      status[2:0] = state_q;
      status[6:4] = fault_q;
      status[16 +: SENSE_W] = sense_s;
   end

   // The FSM always looks at en_q, so a CTRL write lands one cycle after the step it coincides with.
   always_comb begin
      state_d   = state_q;
      fault_d   = fault_q;
      en_d      = (avs_write && avs_address == ADDR_CTRL) ? avs_writedata[0] : en_q;
      irq_en_d  = (avs_write && avs_address == ADDR_CTRL) ? avs_writedata[1] : irq_en_q;
      timeout_d = (avs_write && avs_address == ADDR_TIMEOUT) ? avs_writedata : timeout_q;
      settle_d  = (avs_write && avs_address == ADDR_SETTLE) ? avs_writedata : settle_q;
      case (state_q)
         ST_OFF: if (en_q) state_d = ST_RAMP0;
         ST_RAMP0: begin
            if (timeout_hit) begin
               state_d = ST_FAULT;
               fault_d = FC_TO_RAMP0;
            end else if (!en_q) state_d = ST_SHUTDOWN;
            else if (good0) state_d = ST_SETTLE0;
         end
         ST_SETTLE0: begin
            if (!good0) begin
               state_d = ST_FAULT;
               fault_d = FC_LOSS0;
            end else if (!en_q) state_d = ST_SHUTDOWN;
            else if (settle_done) state_d = ST_RAMP1;
         end
         ST_RAMP1: begin
            if (timeout_hit || !good0) begin
               state_d = ST_FAULT;
               fault_d = timeout_hit ? FC_TO_RAMP1 : FC_LOSS0;
            end else if (!en_q) state_d = ST_SHUTDOWN;
            else if (good1) state_d = ST_ON;
         end
         ST_ON: begin
            if (!good0 || !good1) begin
               state_d = ST_FAULT;
               fault_d = !good0 ? FC_LOSS0 : FC_LOSS1;
            end else if (!en_q) state_d = ST_SHUTDOWN;
         end
         ST_SHUTDOWN: if (settle_done) state_d = ST_OFF;
         ST_FAULT: begin
            if (clear_fault) begin
               state_d = ST_OFF;
               fault_d = FC_NONE;
               en_d    = 1'b0;
            end
         end
         default: state_d = ST_OFF;
      endcase
      cnt_d   = (state_d != state_q) ? 32'd0 : (&cnt_q) ? cnt_q : cnt_q + 32'd1;
      rdata_d = !avs_read ? rdata_q :
                (avs_address == ADDR_CTRL)    ? {30'd0, irq_en_q, en_q} :
                (avs_address == ADDR_STATUS)  ? status :
                (avs_address == ADDR_TIMEOUT) ? timeout_q : settle_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_OFF;
         fault_q   <= FC_NONE;
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         timeout_q <= TIMEOUT_RST;
         settle_q  <= SETTLE_RST;
         cnt_q     <= 32'd0;
         rdata_q   <= 32'd0;
         ctl_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         fault_q   <= fault_d;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         timeout_q <= timeout_d;
         settle_q  <= settle_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         ctl_q     <= rail_ctl(state_d);
      end
   end

   assign power_control = ctl_q;
   assign avs_readdata  = rdata_q;
   assign irq           = irq_en_q && (fault_q != FC_NONE);
endmodule

// File: tb/tb_power_sequencer.sv
// tb_power_sequencer: directed scenario tests for power_sequencer with hand-computed expectations
module tb_power_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avs_address = 2'd0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic [31:0] avs_readdata;
   logic [1:0]  power_control;
   logic [5:0]  power_sense = 6'd0;
   logic        irq;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] rv;

   power_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .power_control (power_control),
      .power_sense   (power_sense),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      avs_address = a;
      avs_writedata = d;
      avs_write = 1'b1;
      tick(1);
      avs_write = 1'b0;
   endtask

   // Returns the register value as it stood when the call was made.
   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read = 1'b1;
      tick(1);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      avs_read = 1'b0;
      avs_write = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic reach_on(input logic [31:0] settle);
      power_sense = 6'h3F;
      do_reset();
      wr(2'd2, 32'd100);
      wr(2'd3, settle);
      tick(1);
      wr(2'd0, 32'd3);
      tick(int'(settle) + 5);
      rd(2'd1, rv);
      checks++; if (rv !== 32'h003F_0004) begin errors++; $display("FAIL reach_on_status: got %h want 003f0004", rv); end
   endtask

   task automatic test_reset();
      power_sense = 6'd0;
      do_reset();
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL reset_ctl: got %b want 00", power_control); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      checks++; if (avs_readdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", avs_readdata); end
      rd(2'd0, rv);
      checks++; if (rv !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", rv); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want 0", rv); end
      rd(2'd2, rv);
      checks++; if (rv !== 32'd5000000) begin errors++; $display("FAIL reset_timeout: got %0d want 5000000", rv); end
      rd(2'd3, rv);
      checks++; if (rv !== 32'd500000) begin errors++; $display("FAIL reset_settle: got %0d want 500000", rv); end
   endtask

   task automatic test_power_up();
      power_sense = 6'd0;
      do_reset();
      wr(2'd2, 32'd100);
      wr(2'd3, 32'd10);
      wr(2'd0, 32'd1);
      tick(1);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL up_ramp0_ctl: got %b want 01", power_control); end
      tick(19);
      power_sense = 6'b000111;
      tick(13);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL up_settle_ctl: got %b want 01", power_control); end
      tick(1);
      checks++; if (power_control !== 2'b11) begin errors++; $display("FAIL up_ramp1_ctl: got %b want 11", power_control); end
      tick(16);
      power_sense = 6'h3F;
      tick(2);
      rd(2'd1, rv);
      checks++; if (rv !== 32'h003F_0003) begin errors++; $display("FAIL up_ramp1_status: got %h want 003f0003", rv); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h003F_0004) begin errors++; $display("FAIL up_on_status: got %h want 003f0004", rv); end
      checks++; if (power_control !== 2'b11) begin errors++; $display("FAIL up_on_ctl: got %b want 11", power_control); end
   endtask

   task automatic test_timeout();
      power_sense = 6'd0;
      do_reset();
      wr(2'd2, 32'd100);
      wr(2'd0, 32'd3);
      tick(101);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL to_pre_ctl: got %b want 01", power_control); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_pre_irq: got %b want 0", irq); end
      tick(1);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL to_ctl: got %b want 00", power_control); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL to_irq: got %b want 1", irq); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h0000_0016) begin errors++; $display("FAIL to_status: got %h want 00000016", rv); end
   endtask

   task automatic test_rail_loss();
      reach_on(32'd2);
      power_sense = 6'h2F;
      tick(2);
      checks++; if (power_control !== 2'b11) begin errors++; $display("FAIL loss_pre_ctl: got %b want 11", power_control); end
      tick(1);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL loss_ctl: got %b want 00", power_control); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL loss_irq: got %b want 1", irq); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h002F_0046) begin errors++; $display("FAIL loss_status: got %h want 002f0046", rv); end
      wr(2'd0, 32'd4);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b want 0", irq); end
      rd(2'd0, rv);
      checks++; if (rv !== 32'd0) begin errors++; $display("FAIL clr_ctrl: got %h want 0", rv); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h002F_0000) begin errors++; $display("FAIL clr_status: got %h want 002f0000", rv); end
      tick(3);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL clr_ctl: got %b want 00", power_control); end
   endtask

   task automatic test_shutdown();
      reach_on(32'd5);
      wr(2'd0, 32'd2);
      tick(1);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL sd_ctl: got %b want 01", power_control); end
      wr(2'd0, 32'd3);
      tick(4);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL sd_hold_ctl: got %b want 01", power_control); end
      tick(1);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL sd_off_ctl: got %b want 00", power_control); end
      tick(1);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL sd_restart_ctl: got %b want 01", power_control); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h003F_0001) begin errors++; $display("FAIL sd_restart_status: got %h want 003f0001", rv); end
   endtask

   task automatic test_timeout_disabled();
      power_sense = 6'd0;
      do_reset();
      wr(2'd2, 32'd0);
      wr(2'd0, 32'd1);
      tick(10000);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL tod_ctl: got %b want 01", power_control); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h0000_0001) begin errors++; $display("FAIL tod_status: got %h want 00000001", rv); end
      wr(2'd2, 32'd5);
      checks++; if (power_control !== 2'b01) begin errors++; $display("FAIL tod_wr_ctl: got %b want 01", power_control); end
      tick(1);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL tod_fault_ctl: got %b want 00", power_control); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h0000_0016) begin errors++; $display("FAIL tod_fault_status: got %h want 00000016", rv); end
   endtask

   task automatic test_reset_mid_and_race();
      power_sense = 6'b000111;
      do_reset();
      wr(2'd2, 32'd100);
      wr(2'd3, 32'd0);
      tick(1);
      wr(2'd0, 32'd1);
      tick(4);
      checks++; if (power_control !== 2'b11) begin errors++; $display("FAIL mid_ctl: got %b want 11", power_control); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h0007_0003) begin errors++; $display("FAIL mid_status: got %h want 00070003", rv); end
      reset = 1'b1;
      tick(1);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL mid_rst_ctl: got %b want 00", power_control); end
      checks++; if (avs_readdata !== 32'd0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", avs_readdata); end
      reset = 1'b0;
      rd(2'd2, rv);
      checks++; if (rv !== 32'd5000000) begin errors++; $display("FAIL mid_rst_timeout: got %0d want 5000000", rv); end
      rd(2'd3, rv);
      checks++; if (rv !== 32'd500000) begin errors++; $display("FAIL mid_rst_settle: got %0d want 500000", rv); end
      rd(2'd0, rv);
      checks++; if (rv !== 32'd0) begin errors++; $display("FAIL mid_rst_ctrl: got %h want 0", rv); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h0007_0000) begin errors++; $display("FAIL mid_rst_status: got %h want 00070000", rv); end
      reach_on(32'd2);
      power_sense = 6'h2F;
      tick(2);
      wr(2'd0, 32'd7);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL race_ctl: got %b want 00", power_control); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq: got %b want 1", irq); end
      rd(2'd1, rv);
      checks++; if (rv !== 32'h002F_0046) begin errors++; $display("FAIL race_status: got %h want 002f0046", rv); end
      wr(2'd0, 32'd7);
      rd(2'd0, rv);
      checks++; if (rv !== 32'd2) begin errors++; $display("FAIL race_clr_ctrl: got %h want 2", rv); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_clr_irq: got %b want 0", irq); end
      tick(2);
      checks++; if (power_control !== 2'b00) begin errors++; $display("FAIL race_clr_ctl: got %b want 00", power_control); end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_timeout();
      test_rail_loss();
      test_shutdown();
      test_timeout_disabled();
      test_reset_mid_and_race();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
